// File: rtl/julia_color_pipe_if.sv
// julia_color_pipe_if: pixel-in / RGB-out valid-ready stream bundle
interface julia_color_pipe_if #(
    parameter int ITER_W = 8,
    parameter int HUE_W  = 9,
    parameter int CH_W   = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [ITER_W-1:0] in_iter;
    logic [HUE_W-1:0]  in_hue;
    logic [1:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [CH_W-1:0]   r;
    logic [CH_W-1:0]   g;
    logic [CH_W-1:0]   b;
    modport master (output in_valid, in_iter, in_hue, in_mode, out_ready,
                    input  in_ready, out_valid, r, g, b);
    modport slave  (input  in_valid, in_iter, in_hue, in_mode, out_ready,
                    output in_ready, out_valid, r, g, b);
endinterface

// File: rtl/julia_color_pipe.sv
// julia_color_pipe: 3-stage fixed-point iteration-count to RGB mapper with animated hue
module julia_color_pipe #(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 100,
    parameter int CH_W     = 8,
    parameter int HUE_W    = 9,
    parameter int HUE_STEP = 10
) (
    input logic clk,
    input logic rst_n,
    input logic frame_start,
    julia_color_pipe_if.slave p
);
    localparam int VMAX = 2**CH_W - 1;
    localparam int PW   = ITER_W + CH_W + 2;
    localparam int XW   = CH_W + 7;

    logic              en;
    logic [8:0]        hue_off;
    logic [9:0]        hue_nxt;
    logic [ITER_W-1:0] it;
    logic [PW-1:0]     vraw;
    logic [CH_W-1:0]   v0;
    logic [8:0]        hb;
    logic [9:0]        hs;
    logic [8:0]        h0;
    logic [2:0]        sec0;
    logic [5:0]        frac0;
    logic [5:0]        fx;
    logic [CH_W-1:0]   x;
    logic [CH_W-1:0]   hr, hg, hbl, rr, gg, bb;

    logic              val1, set1, val2, set2;
    logic [CH_W-1:0]   v1, v2;
    logic [8:0]        h1;
    logic [1:0]        m1, m2;
    logic [2:0]        sec2;
    logic [5:0]        frac2;

    assign en = p.out_ready || !p.out_valid;
    assign p.in_ready = en;

    // stage 1: clamp, scale to value, fold hue into 0..359
    assign it    = (p.in_iter > ITER_W'(MAX_ITER)) ? ITER_W'(MAX_ITER) : p.in_iter;
    assign vraw  = PW'(it) * PW'(2 * VMAX) / PW'(MAX_ITER);
    assign v0    = (vraw > PW'(VMAX)) ? CH_W'(VMAX) : vraw[CH_W-1:0];
    assign hb    = 9'(32'(p.in_hue) % 32'd360);
    assign hs    = {1'b0, hb} + {1'b0, hue_off};
    assign h0    = (hs >= 10'd360) ? 9'(hs - 10'd360) : hs[8:0];

    // stage 2: hue sector and position within it
    assign sec0  = 3'(h1 / 9'd60);
    assign frac0 = 6'(h1 - 9'(sec0) * 9'd60);

    // stage 3: secondary component and sector/mode mux
    assign fx  = sec2[0] ? 6'd60 - frac2 : frac2;
    assign x   = CH_W'(XW'(v2) * XW'(fx) / XW'(60));
    assign hr  = (sec2 == 3'd0 || sec2 == 3'd5) ? v2 : (sec2 == 3'd1 || sec2 == 3'd4) ? x : '0;
    assign hg  = (sec2 == 3'd1 || sec2 == 3'd2) ? v2 : (sec2 == 3'd0 || sec2 == 3'd3) ? x : '0;
    assign hbl = (sec2 == 3'd3 || sec2 == 3'd4) ? v2 : (sec2 == 3'd2 || sec2 == 3'd5) ? x : '0;
    assign rr  = (m2 == 2'd1) ? v2 : (m2 == 2'd2 && set2) ? '0 : hr;
    assign gg  = (m2 == 2'd1) ? v2 : (m2 == 2'd2 && set2) ? '0 : hg;
    assign bb  = (m2 == 2'd1) ? v2 : (m2 == 2'd2 && set2) ? '0 : hbl;

    assign hue_nxt = {1'b0, hue_off} + 10'(HUE_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val1 <= 1'b0; v1 <= '0; h1 <= '0; m1 <= '0; set1 <= 1'b0;
            val2 <= 1'b0; v2 <= '0; sec2 <= '0; frac2 <= '0; m2 <= '0; set2 <= 1'b0;
            p.out_valid <= 1'b0; p.r <= '0; p.g <= '0; p.b <= '0;
        end else if (en) begin
            val1 <= p.in_valid; v1 <= v0; h1 <= h0; m1 <= p.in_mode;
            set1 <= (it == ITER_W'(MAX_ITER));
            val2 <= val1; v2 <= v1; sec2 <= sec0; frac2 <= frac0; m2 <= m1; set2 <= set1;
            p.out_valid <= val2; p.r <= rr; p.g <= gg; p.b <= bb;
        end
    end

    // hue animation runs off frame_start regardless of downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hue_off <= '0;
        else if (frame_start) hue_off <= (hue_nxt >= 10'd360) ? 9'(hue_nxt - 10'd360) : hue_nxt[8:0];
    end
endmodule

// File: tb/tb_julia_color_pipe.sv
// tb_julia_color_pipe: directed vectors with hand-computed RGB expectations
module tb_julia_color_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [23:0] rgb;
    logic [23:0] sexp [10] = '{24'h190000, 24'h333300, 24'h004C00, 24'h006666, 24'h00007F,
                               24'h990099, 24'hB20000, 24'hCCCC00, 24'h00E500, 24'h00FFFF};

    julia_color_pipe_if #(.ITER_W(8), .HUE_W(9), .CH_W(8)) pif ();

    julia_color_pipe #(.ITER_W(8), .MAX_ITER(100), .CH_W(8), .HUE_W(9), .HUE_STEP(10)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .p(pif.slave)
    );

    assign rgb = {pif.r, pif.g, pif.b};
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic px(input string tag, input int iter, input int hue, input int mode, input logic [23:0] e);
        pif.in_valid = 1'b1; pif.in_iter = 8'(iter); pif.in_hue = 9'(hue); pif.in_mode = 2'(mode);
        @(posedge clk); #1;
        pif.in_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_early"}, 32'(pif.out_valid), 0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, 32'(pif.out_valid), 1);
        chk(tag, 32'(rgb), 32'(e));
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            @(posedge clk); #1;
            frame_start = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int sent, ngot;
        bit acc, hv;
        logic [23:0] held;
        pif.in_valid = 1'b0; pif.in_iter = '0; pif.in_hue = '0; pif.in_mode = '0; pif.out_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(pif.out_valid), 0);
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_ready", 32'(pif.in_ready), 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        px("m0_red", 50, 0, 0, 24'hFF0000);
        px("m0_h90", 25, 90, 0, 24'h3F7F00);
        px("m0_h240", 25, 240, 0, 24'h00007F);
        px("m0_full", 100, 0, 0, 24'hFF0000);
        px("m2_inset", 100, 0, 2, 24'h000000);
        px("m2_notset", 50, 0, 2, 24'hFF0000);
        px("clamp", 150, 0, 0, 24'hFF0000);
        px("m1_gray", 25, 90, 1, 24'h7F7F7F);
        px("m3_h90", 25, 90, 3, 24'h3F7F00);
        for (int m = 0; m < 4; m++) px("zero_iter", 0, 90, m, 24'h000000);

        pulse(3);
        px("off30", 50, 350, 0, 24'hFF5500);
        pulse(33);
        px("off_wrap0", 50, 0, 0, 24'hFF0000);
        px("hue500", 50, 500, 0, 24'h00FF55);

        pif.in_valid = 1'b1; pif.in_iter = 8'd50; pif.in_hue = 9'd0; pif.in_mode = 2'd0; frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(posedge clk); #1;
        pif.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("simul_old", 32'(rgb), 32'h00FF0000);
        @(posedge clk); #1;
        chk("simul_new_v", 32'(pif.out_valid), 1);
        chk("simul_new", 32'(rgb), 32'h00FF2A00);
        pulse(35);

        sent = 0; ngot = 0; hv = 1'b0; held = '0;
        for (int c = 0; c < 60 && ngot < 10; c++) begin
            pif.out_ready = !(c >= 4 && c < 9);
            pif.in_valid = (sent < 10);
            pif.in_iter = 8'(5 * (sent + 1));
            pif.in_hue = 9'(60 * (sent % 6));
            pif.in_mode = 2'd0;
            @(negedge clk);
            acc = pif.in_valid && pif.in_ready;
            if (pif.out_valid && pif.out_ready) begin
                chk("stream", 32'(rgb), 32'(sexp[ngot]));
                ngot++;
            end
            if (!pif.out_ready) begin
                chk("stall_ready", 32'(pif.in_ready), 0);
                if (hv) chk("stall_hold", 32'({pif.out_valid, rgb}), 32'({1'b1, held}));
                else begin held = rgb; hv = 1'b1; end
            end
            @(posedge clk); #1;
            if (acc) sent++;
        end
        chk("stream_count", 32'(ngot), 10);
        pif.in_valid = 1'b0; pif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_dup", 32'(pif.out_valid), 0);
        end
        @(posedge clk); #1;

        pulse(1);
        pif.in_valid = 1'b1; pif.in_iter = 8'd50; pif.in_hue = 9'd0;
        repeat (3) @(posedge clk);
        #1 pif.in_valid = 1'b0;
        chk("pre_rst_valid", 32'(pif.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(pif.out_valid), 0);
        chk("mid_rst_rgb", 32'(rgb), 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_rst_empty", 32'(pif.out_valid), 0);
        end
        px("post_rst_off0", 50, 0, 0, 24'hFF0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
